// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes and the divider state encoding.
package alu_pkg;

    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it stays non-negative.
module div_step #(
    parameter int width = 6
) (
    input  logic [width:0]   rem,
    input  logic [width-1:0] quo,
    input  logic [width-1:0] dvs,
    output logic [width:0]   rem_n,
    output logic [width-1:0] quo_n
);

    logic [width:0] shifted_s;
    logic [width:0] trial_s;
    logic           unused_rem_msb_s;

    // The partial remainder is always below the divisor, so its top bit carries no information.
    assign unused_rem_msb_s = rem[width];

    // Trial subtraction and restore decision.
    always_comb begin
        shifted_s = {rem[width-1:0], quo[width-1]};
        trial_s   = shifted_s - {1'b0, dvs};
        if (trial_s[width] == 1'b0) begin
            rem_n = trial_s;
            quo_n = {quo[width-2:0], 1'b1};
        end else begin
            rem_n = shifted_s;
            quo_n = {quo[width-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Result is packed as {remainder, quotient}; divide by zero finishes immediately with ovf set.
module div_seq
    import alu_pkg::*;
#(
    parameter int width = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*width-1:0] out,
    output logic               ovf
);

    localparam int CNT_W = $clog2(width + 1);

    div_state_t         state_q, state_d;
    logic [width:0]     rem_q, rem_d;
    logic [width-1:0]   quo_q, quo_d;
    logic [width-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*width-1:0] out_q, out_d;
    logic               ovf_q, ovf_d;
    logic [width:0]     rem_n_s;
    logic [width-1:0]   quo_n_s;

    div_step #(.width(width)) u_step (
        .rem   (rem_q),
        .quo   (quo_q),
        .dvs   (dvs_q),
        .rem_n (rem_n_s),
        .quo_n (quo_n_s)
    );

    // Next-state, working-register and result update logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b != {width{1'b0}}) begin
                        state_d = RUN;
                        rem_d   = {(width + 1){1'b0}};
                        quo_d   = a;
                        dvs_d   = b;
                        cnt_d   = CNT_W'(width);
                    end else begin
                        state_d = DONE;
                        out_d   = {a, {width{1'b1}}};
                        ovf_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_n_s;
                quo_d = quo_n_s;
                cnt_d = cnt_q - CNT_W'(1);
                // The last iteration's result goes straight into the output register.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    out_d   = {rem_n_s[width-1:0], quo_n_s};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= {(width + 1){1'b0}};
            quo_q   <= {width{1'b0}};
            dvs_q   <= {width{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            out_q   <= {(2 * width){1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq at width 6.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] out;
    logic        ovf;

    int checks;
    int errors;
    int n;

    div_seq #(.width(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done; cyc is the cycle done appeared in.
    task automatic do_div(input logic [5:0] da, input logic [5:0] db, output int cyc);
        start = 1'b1;
        a     = da;
        b     = db;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 6'd0;
        b      = 6'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out", 32'(out), 32'h000);
        check("reset_ovf", 32'(ovf), 32'd0);

        // 45 / 7 with cycle-accurate busy/done
        start = 1'b1;
        a     = 6'd45;
        b     = 6'd7;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("d45_busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("d45_done_c%0d", c), 32'(done), (c == 7) ? 32'd1 : 32'd0);
        end
        check("d45_out", 32'(out), 32'h0C6);
        check("d45_ovf", 32'(ovf), 32'd0);
        tick();
        check("d45_idle_busy", 32'(busy), 32'd0);
        check("d45_idle_done", 32'(done), 32'd0);
        check("d45_hold_out", 32'(out), 32'h0C6);

        do_div(6'd63, 6'd1, n);
        check("d63_1_cycle", 32'(n), 32'd7);
        check("d63_1_out", 32'(out), 32'h03F);
        tick();

        do_div(6'd5, 6'd9, n);
        check("d5_9_cycle", 32'(n), 32'd7);
        check("d5_9_out", 32'(out), 32'h140);
        tick();

        // divide by zero
        start = 1'b1;
        a     = 6'd20;
        b     = 6'd0;
        tick();
        start = 1'b0;
        check("dz_done", 32'(done), 32'd1);
        check("dz_busy", 32'(busy), 32'd1);
        check("dz_ovf", 32'(ovf), 32'd1);
        check("dz_out", 32'(out), 32'h53F);
        tick();
        check("dz_busy_after", 32'(busy), 32'd0);
        check("dz_done_after", 32'(done), 32'd0);
        do_div(6'd45, 6'd7, n);
        check("dz_clear_cycle", 32'(n), 32'd7);
        check("dz_clear_ovf", 32'(ovf), 32'd0);
        check("dz_clear_out", 32'(out), 32'h0C6);
        tick();

        // start while busy is ignored, operand changes do not matter
        do_div(6'd20, 6'd0, n);
        tick();
        start = 1'b1;
        a     = 6'd45;
        b     = 6'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 6'd10;
        b     = 6'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("busy_ign_done", 32'(done), 32'd1);
        check("busy_ign_out", 32'(out), 32'h0C6);
        check("busy_ign_ovf", 32'(ovf), 32'd0);
        tick();
        check("busy_ign_idle", 32'(busy), 32'd0);

        // reset in cycle 3 of a divide
        start = 1'b1;
        a     = 6'd63;
        b     = 6'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out", 32'(out), 32'h000);
        check("rst_ovf", 32'(ovf), 32'd0);
        for (int c = 4; c <= 10; c++) begin
            check($sformatf("rst_nodone_c%0d", c), 32'(done), 32'd0);
            tick();
        end

        // start held through DONE is only taken in the following IDLE cycle
        do_div(6'd5, 6'd9, n);
        check("b2b_first_out", 32'(out), 32'h140);
        start = 1'b1;
        a     = 6'd63;
        b     = 6'd8;
        tick();
        check("b2b_done_ign_busy", 32'(busy), 32'd0);
        check("b2b_done_ign_done", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        check("b2b_accept_busy", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("b2b_cycle", 32'(n), 32'd7);
        check("b2b_out", 32'(out), 32'h1C7);
        check("b2b_ovf", 32'(ovf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
